// File: rtl/mult_div_unit_pkg.sv
// Shared op and HI/LO select encodings for the multiply/divide unit and decoder.
package mult_div_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;

    localparam logic HL_HI = 1'b0;
    localparam logic HL_LO = 1'b1;

    // Only the four codes with op[2]==0 start an operation.
    function automatic logic md_op_valid(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

    // op[1] separates the divide class from the multiply class.
    function automatic logic md_op_is_div(input logic [2:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational multiply/divide datapath producing HI/LO results for one op.
module md_arith
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_zero
);

    logic                   is_signed;
    logic [2*WIDTH-1:0]     ext_a;
    logic [2*WIDTH-1:0]     ext_b;
    logic [2*WIDTH-1:0]     prod;
    logic                   neg_a;
    logic                   neg_b;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [WIDTH-1:0]       safe_b;
    logic [WIDTH-1:0]       quo;
    logic [WIDTH-1:0]       rem;

    // One shared multiplier (sign/zero extension picks the flavour) and a
    // magnitude divider; signed division fixes up signs afterwards, which also
    // yields min_int / -1 = min_int, remainder 0 without a special case.
    always_comb begin
        res_hi    = '0;
        res_lo    = '0;
        div_zero  = 1'b0;
        is_signed = ~op[0];
        ext_a     = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
        ext_b     = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
        prod      = ext_a * ext_b;
        neg_a     = is_signed & a[WIDTH-1];
        neg_b     = is_signed & b[WIDTH-1];
        mag_a     = neg_a ? -a : a;
        mag_b     = neg_b ? -b : b;
        safe_b    = (b == '0) ? WIDTH'(1) : mag_b;
        quo       = mag_a / safe_b;
        rem       = mag_a % safe_b;
        case (op)
            MD_MULT, MD_MULTU: begin
                res_hi = prod[2*WIDTH-1:WIDTH];
                res_lo = prod[WIDTH-1:0];
            end
            MD_DIV, MD_DIVU: begin
                res_lo   = (neg_a ^ neg_b) ? -quo : quo;
                res_hi   = neg_a ? -rem : rem;
                div_zero = (b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hl_write,
    input  logic             hl_sel,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_N   = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N    = CW'(DIV_CYCLES);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_dz;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             div_zero;
    logic             hl_wr;
    logic             accept;

    md_arith #(.WIDTH(WIDTH)) u_arith (
        .op       (op),
        .a        (a),
        .b        (b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign hl_wr  = hl_write & ~flush;
    assign accept = start & ~flush & ~busy & ~hl_write & md_op_valid(op);
    assign rdata  = (hl_sel == HL_LO) ? lo : hi;

    // HI/LO writes win over everything and abort an in-flight op; otherwise
    // accept a new op or count the current one down and commit at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_dz <= 1'b0;
        end else if (hl_wr) begin
            if (hl_sel == HL_LO) begin
                lo <= wdata;
            end else begin
                hi <= wdata;
            end
            busy  <= 1'b0;
            count <= '0;
        end else if (accept) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_dz <= div_zero;
            count   <= md_op_is_div(op) ? DIV_N : MULT_N;
            busy    <= 1'b1;
        end else if (busy) begin
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                busy <= 1'b0;
                if (!pend_dz) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed test-plan cases plus random ops.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          hl_write = 1'b0;
    logic          hl_sel = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          flush = 1'b0;
    logic          busy;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic [W-1:0]  rdata;

    mult_div_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hl_write(hl_write), .hl_sel(hl_sel), .wdata(wdata), .flush(flush),
        .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
        string       name;
    } done_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        busy;
        string       name;
    } probe_t;

    done_t  sb[$];
    probe_t pq[$];
    done_t  d_cur;
    probe_t p_cur;

    int n_vec = 0;
    int n_bad = 0;
    int run_len = 0;
    logic prev_busy = 1'b0;
    bit finishing = 1'b0;
    bit mon_done = 1'b0;

    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: consumes probes, checks each busy fall against the scoreboard.
    always @(negedge clk) begin
        if (pq.size() > 0) begin
            p_cur = pq.pop_front();
            cmp({p_cur.name, " busy"}, {31'b0, busy}, {31'b0, p_cur.busy});
            cmp({p_cur.name, " hi"}, hi, p_cur.hi);
            cmp({p_cur.name, " lo"}, lo, p_cur.lo);
            cmp({p_cur.name, " rdata"}, rdata, hl_sel ? p_cur.lo : p_cur.hi);
        end
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (sb.size() == 0) begin
                cmp("unexpected busy fall", 32'd1, 32'd0);
            end else begin
                d_cur = sb.pop_front();
                cmp({d_cur.name, " result hi"}, hi, d_cur.hi);
                cmp({d_cur.name, " result lo"}, lo, d_cur.lo);
                cmp({d_cur.name, " busy cycles"}, run_len, d_cur.len);
            end
        end
        if (busy === 1'b1) run_len++;
        else run_len = 0;
        prev_busy = busy;
        if (finishing && !mon_done) begin
            cmp("outstanding ops", sb.size(), 0);
            mon_done = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string nm, input logic exp_busy);
        pq.push_back('{model_hi, model_lo, exp_busy, nm});
    endtask

    // Reference results from plain integer arithmetic.
    function automatic void ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l, output bit dz);
        longint          sp;
        longint unsigned up;
        int              sx;
        int              sy;
        h = '0; l = '0; dz = 1'b0;
        case (o)
            MD_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {h, l} = sp;
            end
            MD_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                {h, l} = up;
            end
            MD_DIV: begin
                if (y == 0) dz = 1'b1;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    l = x; h = '0;
                end else begin
                    sx = x; sy = y;
                    l = 32'(sx / sy);
                    h = 32'(sx % sy);
                end
            end
            MD_DIVU: begin
                if (y == 0) dz = 1'b1;
                else begin
                    l = x / y;
                    h = x % y;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic wait_idle;
        for (int i = 0; i < DC + 5; i++) begin
            if (busy === 1'b0) break;
            tick;
        end
        if (busy !== 1'b0) probe("idle timeout", 1'b0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit extra, input string nm);
        logic [31:0] eh;
        logic [31:0] el;
        bit          dz;
        start = 1'b1; op = o; a = x; b = y;
        tick;
        start = 1'b0;
        ref_md(o, x, y, eh, el, dz);
        sb.push_back('{dz ? model_hi : eh, dz ? model_lo : el, o[1] ? DC : MC, nm});
        probe({nm, " in flight"}, 1'b1);
        if (extra) begin
            start = 1'b1; op = MD_MULT; a = $urandom; b = $urandom;
            tick;
            start = 1'b0;
        end
        wait_idle;
        if (!dz) begin
            model_hi = eh;
            model_lo = el;
        end
    endtask

    task automatic hl_wr(input logic sel, input logic [31:0] data, input logic fl, input string nm);
        hl_write = 1'b1; hl_sel = sel; wdata = data; flush = fl;
        tick;
        hl_write = 1'b0; flush = 1'b0;
        if (!fl) begin
            if (sel) model_lo = data;
            else model_hi = data;
        end
        probe(nm, 1'b0);
    endtask

    task automatic flushed_start(input logic [2:0] o);
        start = 1'b1; flush = 1'b1; op = o; a = $urandom; b = $urandom;
        tick;
        start = 1'b0; flush = 1'b0;
        probe("flushed start", 1'b0);
    endtask

    task automatic invalid_op;
        start = 1'b1; op = 3'($urandom_range(4, 7)); a = $urandom; b = $urandom;
        tick;
        start = 1'b0;
        probe("invalid op", 1'b0);
    endtask

    // Bounded run time regardless of DUT behaviour.
    initial begin
        #1_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // Stimulus: directed test-plan cases, then randomized traffic.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          r;
        tick;
        probe("reset hi sel", 1'b0);
        hl_sel = 1'b1;
        tick;
        probe("reset lo sel", 1'b0);
        reset = 1'b0;
        tick;

        do_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, "mult -2*3");
        do_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, "div -7/2");
        do_op(MD_DIVU,  32'd7,         32'd2, 1'b0, "divu 7/2");
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div overflow");
        hl_wr(HL_HI, 32'h11, 1'b0, "mthi");
        hl_wr(HL_LO, 32'h22, 1'b0, "mtlo");
        do_op(MD_DIVU,  32'd1234,      32'd0, 1'b0, "divu by zero");
        flushed_start(MD_MULT);
        hl_wr(HL_LO, 32'h55, 1'b1, "flushed mtlo");

        // hl_write two cycles into a mult aborts it
        start = 1'b1; op = MD_MULT; a = 32'd9; b = 32'd9;
        tick;
        start = 1'b0;
        probe("abort in flight", 1'b1);
        tick;
        hl_write = 1'b1; hl_sel = HL_HI; wdata = 32'hABCD;
        sb.push_back('{32'hABCD, model_lo, 2, "mthi abort"});
        tick;
        hl_write = 1'b0;
        model_hi = 32'hABCD;
        repeat (MC + 3) tick;
        probe("no commit after abort", 1'b0);

        do_op(MD_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1, "start while busy");

        // reset four cycles into a div
        start = 1'b1; op = MD_DIV; a = 32'd100; b = 32'd7;
        tick;
        start = 1'b0;
        sb.push_back('{32'h0, 32'h0, 4, "reset abort"});
        repeat (3) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        model_hi = '0;
        model_lo = '0;
        repeat (DC + 3) tick;
        probe("no commit after reset", 1'b0);

        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(0, 20));
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            if (r <= 5) do_op(3'(r % 4), ra, rb, 1'b0, "random op");
            else if (r <= 7) hl_wr(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), "random hl write");
            else if (r == 8) invalid_op;
            else flushed_start(3'($urandom_range(0, 3)));
        end

        finishing = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (mon_done) break;
            tick;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
